// File: rtl/fwd_pkg.sv
// Shared types and defaults for the EX-stage forwarding/scoreboard block.
package fwd_pkg;
  localparam int DW_DEF   = 32;
  localparam int NREG_DEF = 32;

  typedef enum logic [2:0] {
    OP_ALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_MULDIV
  } opcode_e;

  typedef enum logic [2:0] {
    FS_ZERO, FS_MEM, FS_MD, FS_WB, FS_RF
  } fwd_sel_e;
endpackage

// File: rtl/fwd_port_mux.sv
// Per-port forwarding select and operand mux (priority: r0, MEM, multdiv, WB, regfile).
// The select is exported only when FWD_PERF_EN is defined.
module fwd_port_mux
  import fwd_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = 5
) (
  input  logic [AW-1:0] i_rs,
  input  logic [DW-1:0] i_hold,
  input  logic          i_m_wr_en,
  input  logic          i_m_is_load,
  input  logic [AW-1:0] i_m_wr_reg,
  input  logic [DW-1:0] i_m_data,
  input  logic          i_md_done,
  input  logic [AW-1:0] i_md_rd,
  input  logic [DW-1:0] i_md_data,
  input  logic          i_w_wr_en,
  input  logic [AW-1:0] i_w_wr_reg,
  input  logic [DW-1:0] i_w_data,
`ifdef FWD_PERF_EN
  output fwd_sel_e      o_sel,
`endif
  output logic [DW-1:0] o_data
);
  fwd_sel_e w_sel;

  always_comb begin
    w_sel = FS_RF;
    if (i_rs == '0)
      w_sel = FS_ZERO;
    else if (i_m_wr_en && !i_m_is_load && (i_m_wr_reg == i_rs))
      w_sel = FS_MEM;
    else if (i_md_done && (i_md_rd == i_rs))
      w_sel = FS_MD;
    else if (i_w_wr_en && (i_w_wr_reg == i_rs))
      w_sel = FS_WB;
  end

  always_comb begin
    o_data = i_hold;
    case (w_sel)
      FS_ZERO: o_data = '0;
      FS_MEM:  o_data = i_m_data;
      FS_MD:   o_data = i_md_data;
      FS_WB:   o_data = i_w_data;
      default: o_data = i_hold;
    endcase
  end

`ifdef FWD_PERF_EN
  assign o_sel = w_sel;
`endif
endmodule

// File: rtl/fwd_scoreboard.sv
// EX operand forwarding plus a one-entry multdiv scoreboard producing the pipeline stall.
// Define FWD_PERF_EN to add saturating stall/forward performance counters.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter  int DW    = DW_DEF,
  parameter  int NREG  = NREG_DEF,
  parameter  int NPORT = 2,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NPORT*AW-1:0] ex_rs,
  input  logic [NPORT-1:0]    ex_rs_vld,
  input  logic [NPORT*DW-1:0] hold_data,
  input  logic                m_wr_en,
  input  logic [AW-1:0]       m_wr_reg,
  input  logic                m_is_load,
  input  logic [DW-1:0]       m_data,
  input  logic                w_wr_en,
  input  logic [AW-1:0]       w_wr_reg,
  input  logic [DW-1:0]       w_data,
  input  logic                md_issue,
  input  logic [AW-1:0]       md_rd,
  input  logic                md_done,
  input  logic [DW-1:0]       md_data,
  output logic [NPORT*DW-1:0] fwd_data,
  output logic                stall,
  output logic                md_busy
`ifdef FWD_PERF_EN
  ,
  output logic [31:0]         perf_lu,
  output logic [31:0]         perf_md,
  output logic [31:0]         perf_fwd
`endif
);
  logic          r_pend_vld;
  logic [AW-1:0] r_pend_reg;
  logic          w_md_done_v;
  logic          w_pend_act;
  logic          w_lu, w_raw, w_waw, w_struct, w_md_stall;
  logic          w_accept;
`ifdef FWD_PERF_EN
  fwd_sel_e      w_sel [NPORT];
`endif

  // A completion with nothing pending (e.g. after reset) is dropped entirely.
  assign w_md_done_v = md_done && r_pend_vld;
  assign w_pend_act  = r_pend_vld && !md_done;

  for (genvar gp = 0; gp < NPORT; gp++) begin : g_port
    fwd_port_mux #(.DW(DW), .AW(AW)) u_mux (
      .i_rs        (ex_rs[gp*AW +: AW]),
      .i_hold      (hold_data[gp*DW +: DW]),
      .i_m_wr_en   (m_wr_en),
      .i_m_is_load (m_is_load),
      .i_m_wr_reg  (m_wr_reg),
      .i_m_data    (m_data),
      .i_md_done   (w_md_done_v),
      .i_md_rd     (md_rd),
      .i_md_data   (md_data),
      .i_w_wr_en   (w_wr_en),
      .i_w_wr_reg  (w_wr_reg),
      .i_w_data    (w_data),
`ifdef FWD_PERF_EN
      .o_sel       (w_sel[gp]),
`endif
      .o_data      (fwd_data[gp*DW +: DW])
    );
  end

  always_comb begin
    w_lu  = 1'b0;
    w_raw = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      if (ex_rs_vld[p] && (ex_rs[p*AW +: AW] != '0)) begin
        if (m_wr_en && m_is_load && (ex_rs[p*AW +: AW] == m_wr_reg))
          w_lu = 1'b1;
        if (w_pend_act && (ex_rs[p*AW +: AW] == r_pend_reg))
          w_raw = 1'b1;
      end
    end
  end

  // WAW: a younger write to the pending register would later be clobbered by the multdiv result.
  assign w_waw      = w_pend_act && ((m_wr_en && (m_wr_reg == r_pend_reg)) ||
                                     (w_wr_en && (w_wr_reg == r_pend_reg)));
  assign w_struct   = md_issue && w_pend_act;
  assign w_md_stall = w_raw || w_waw || w_struct;
  assign stall      = reset && (w_lu || w_md_stall);
  assign w_accept   = md_issue && !stall && (md_rd != '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pend_vld <= 1'b0;
      r_pend_reg <= '0;
    end else if (w_accept) begin
      r_pend_vld <= 1'b1;
      r_pend_reg <= md_rd;
    end else if (w_md_done_v) begin
      r_pend_vld <= 1'b0;
    end
  end

  assign md_busy = r_pend_vld;

`ifdef FWD_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && !(&v)) ? v + 32'd1 : v;
  endfunction

  logic        w_any_fwd;
  logic [31:0] r_perf_lu, r_perf_md, r_perf_fwd;

  always_comb begin
    w_any_fwd = 1'b0;
    for (int p = 0; p < NPORT; p++)
      if (w_sel[p] == FS_MEM || w_sel[p] == FS_MD || w_sel[p] == FS_WB)
        w_any_fwd = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_perf_lu  <= '0;
      r_perf_md  <= '0;
      r_perf_fwd <= '0;
    end else begin
      r_perf_lu  <= sat_inc(r_perf_lu, w_lu);
      r_perf_md  <= sat_inc(r_perf_md, w_md_stall);
      r_perf_fwd <= sat_inc(r_perf_fwd, w_any_fwd);
    end
  end

  assign perf_lu  = r_perf_lu;
  assign perf_md  = r_perf_md;
  assign perf_fwd = r_perf_fwd;
`endif
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed, table-driven bench for fwd_scoreboard (NPORT=2, DW=32, NREG=32).
module tb_fwd_scoreboard;
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  ex_rs;
  logic [1:0]  ex_rs_vld;
  logic [63:0] hold_data;
  logic        m_wr_en, m_is_load, w_wr_en, md_issue, md_done;
  logic [4:0]  m_wr_reg, w_wr_reg, md_rd;
  logic [31:0] m_data, w_data, md_data;
  logic [63:0] fwd_data;
  logic        stall, md_busy;
`ifdef FWD_PERF_EN
  logic [31:0] perf_lu, perf_md, perf_fwd;
`endif

  always #5 clk = ~clk;

  fwd_scoreboard #(.DW(32), .NREG(32), .NPORT(2)) dut (
    .clock(clk), .reset(reset), .ex_rs(ex_rs), .ex_rs_vld(ex_rs_vld),
    .hold_data(hold_data), .m_wr_en(m_wr_en), .m_wr_reg(m_wr_reg),
    .m_is_load(m_is_load), .m_data(m_data), .w_wr_en(w_wr_en),
    .w_wr_reg(w_wr_reg), .w_data(w_data), .md_issue(md_issue), .md_rd(md_rd),
    .md_done(md_done), .md_data(md_data), .fwd_data(fwd_data), .stall(stall),
    .md_busy(md_busy)
`ifdef FWD_PERF_EN
    , .perf_lu(perf_lu), .perf_md(perf_md), .perf_fwd(perf_fwd)
`endif
  );

  typedef struct {
    logic [4:0]  rs0, rs1;
    logic [1:0]  vld;
    logic        m_en;
    logic [4:0]  m_reg;
    logic        m_ld;
    logic [31:0] m_dat;
    logic        w_en;
    logic [4:0]  w_reg;
    logic [31:0] w_dat;
    logic        d_done;
    logic [4:0]  d_rd;
    logic [31:0] d_dat;
    logic [31:0] e0, e1;
    logic        e_st;
    logic        e_fw;
  } vec_t;

  vec_t vecs [10];
  int total = 0, bad = 0;
  int exp_lu = 0, exp_md = 0, exp_fw = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    ex_rs = '0; ex_rs_vld = '0;
    hold_data = {32'h0000_00B1, 32'h0000_00A0};
    m_wr_en = 0; m_wr_reg = 0; m_is_load = 0; m_data = 0;
    w_wr_en = 0; w_wr_reg = 0; w_data = 0;
    md_issue = 0; md_rd = 0; md_done = 0; md_data = 0;
  endtask

  task automatic set_rs(input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] v);
    ex_rs = {r1, r0};
    ex_rs_vld = v;
  endtask

  task automatic tick(input bit lu, input bit md, input bit fw);
    exp_lu += int'(lu);
    exp_md += int'(md);
    exp_fw += int'(fw);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_perf(input string tag);
`ifdef FWD_PERF_EN
    chk({tag, "_perf_lu"},  perf_lu,  exp_lu);
    chk({tag, "_perf_md"},  perf_md,  exp_md);
    chk({tag, "_perf_fwd"}, perf_fwd, exp_fw);
`else
    if (tag.len() == 0) $display("no tag");
`endif
  endtask

  initial begin
    //        rs0 rs1 vld    m_en m_reg ld m_dat          w_en w_reg w_dat         dn rd d_dat         e0             e1             st fw
    vecs[0] = '{5, 6, 2'b11, 1, 5, 0, 32'h11,   1, 5, 32'h22,   0, 0, 32'h0,  32'h11,   32'hB1,   0, 1};
    vecs[1] = '{5, 6, 2'b11, 0, 5, 0, 32'h11,   1, 5, 32'h22,   0, 0, 32'h0,  32'h22,   32'hB1,   0, 1};
    vecs[2] = '{0, 0, 2'b11, 1, 0, 0, 32'hFFFF, 1, 0, 32'h5555, 0, 0, 32'h0,  32'h0,    32'h0,    0, 0};
    vecs[3] = '{1, 7, 2'b11, 1, 7, 1, 32'h77,   0, 0, 32'h0,    0, 0, 32'h0,  32'hA0,   32'hB1,   1, 0};
    vecs[4] = '{1, 7, 2'b01, 1, 7, 1, 32'h77,   0, 0, 32'h0,    0, 0, 32'h0,  32'hA0,   32'hB1,   0, 0};
    vecs[5] = '{0, 2, 2'b11, 1, 0, 1, 32'h77,   0, 0, 32'h0,    0, 0, 32'h0,  32'h0,    32'hB1,   0, 0};
    vecs[6] = '{7, 7, 2'b11, 1, 7, 1, 32'h77,   1, 7, 32'h7777, 0, 0, 32'h0,  32'h7777, 32'h7777, 1, 1};
    vecs[7] = '{3, 4, 2'b11, 0, 0, 0, 32'h0,    0, 0, 32'h0,    1, 3, 32'h33, 32'hA0,   32'hB1,   0, 0};
    vecs[8] = '{8, 9, 2'b11, 1, 10, 0, 32'h1,   1, 11, 32'h2,   0, 0, 32'h0,  32'hA0,   32'hB1,   0, 0};
    vecs[9] = '{6, 5, 2'b11, 1, 5, 0, 32'h55,   1, 6, 32'h66,   0, 0, 32'h0,  32'h66,   32'h55,   0, 1};

    // Reset: outputs quiet even with a load-use hazard on the inputs
    reset = 1'b0;
    idle();
    m_wr_en = 1; m_wr_reg = 7; m_is_load = 1; set_rs(0, 7, 2'b10);
    #3;
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_busy", {31'b0, md_busy}, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    idle();

    // Combinational forwarding / load-use table
    for (int i = 0; i < 10; i++) begin
      idle();
      set_rs(vecs[i].rs0, vecs[i].rs1, vecs[i].vld);
      m_wr_en = vecs[i].m_en; m_wr_reg = vecs[i].m_reg; m_is_load = vecs[i].m_ld; m_data = vecs[i].m_dat;
      w_wr_en = vecs[i].w_en; w_wr_reg = vecs[i].w_reg; w_data = vecs[i].w_dat;
      md_done = vecs[i].d_done; md_rd = vecs[i].d_rd; md_data = vecs[i].d_dat;
      #2;
      chk($sformatf("v%0d_fwd0", i), fwd_data[31:0], vecs[i].e0);
      chk($sformatf("v%0d_fwd1", i), fwd_data[63:32], vecs[i].e1);
      chk($sformatf("v%0d_stall", i), {31'b0, stall}, {31'b0, vecs[i].e_st});
      tick(vecs[i].e_st, 1'b0, vecs[i].e_fw);
    end

    // Load-use on port1 (multdiv issue in the stalled cycle is ignored), then WB forward
    idle();
    m_wr_en = 1; m_wr_reg = 7; m_is_load = 1; set_rs(0, 7, 2'b10);
    md_issue = 1; md_rd = 10;
    #2;
    chk("lu_stall", {31'b0, stall}, 1);
    tick(1, 0, 0);
    idle();
    w_wr_en = 1; w_wr_reg = 7; w_data = 32'h1234; set_rs(0, 7, 2'b10);
    #2;
    chk("lu_wb_stall", {31'b0, stall}, 0);
    chk("lu_wb_fwd1", fwd_data[63:32], 32'h1234);
    chk("lu_issue_ignored", {31'b0, md_busy}, 0);
    tick(0, 0, 1);

    // Multdiv r9: WAW, RAW stall until done, forward md_data, busy drops next cycle
    idle(); md_issue = 1; md_rd = 9;
    #2; chk("md9_issue_stall", {31'b0, stall}, 0);
    tick(0, 0, 0);
    idle(); w_wr_en = 1; w_wr_reg = 9; w_data = 32'h5;
    #2;
    chk("md9_busy", {31'b0, md_busy}, 1);
    chk("md9_waw", {31'b0, stall}, 1);
    tick(0, 1, 0);
    idle();
    #2; chk("md9_idle", {31'b0, stall}, 0);
    tick(0, 0, 0);
    for (int c = 0; c < 2; c++) begin
      idle(); set_rs(9, 0, 2'b01);
      #2; chk($sformatf("md9_raw%0d", c), {31'b0, stall}, 1);
      tick(0, 1, 0);
    end
    idle(); set_rs(9, 0, 2'b01); md_done = 1; md_rd = 9; md_data = 32'h9999;
    #2;
    chk("md9_done_stall", {31'b0, stall}, 0);
    chk("md9_done_fwd", fwd_data[31:0], 32'h9999);
    chk("md9_done_busy", {31'b0, md_busy}, 1);
    tick(0, 0, 1);
    idle(); set_rs(9, 0, 2'b01);
    #2;
    chk("md9_after_busy", {31'b0, md_busy}, 0);
    chk("md9_after_stall", {31'b0, stall}, 0);
    chk("md9_after_fwd", fwd_data[31:0], 32'hA0);
    tick(0, 0, 0);

    // Structural stall, then done + retry in the same cycle
    idle(); md_issue = 1; md_rd = 4;
    #2; chk("st_issue4", {31'b0, stall}, 0);
    tick(0, 0, 0);
    idle(); md_issue = 1; md_rd = 6;
    #2; chk("st_struct", {31'b0, stall}, 1);
    tick(0, 1, 0);
    idle(); md_issue = 1; md_rd = 6; md_done = 1; md_data = 32'h44;
    #2; chk("st_retry_stall", {31'b0, stall}, 0);
    tick(0, 0, 0);
    idle(); set_rs(6, 0, 2'b01);
    #2;
    chk("st_busy", {31'b0, md_busy}, 1);
    chk("st_pend6", {31'b0, stall}, 1);
    tick(0, 1, 0);
    idle(); set_rs(4, 0, 2'b01);
    #2; chk("st_not4", {31'b0, stall}, 0);
    tick(0, 0, 0);
    idle(); md_done = 1; md_rd = 6; md_data = 32'h66;
    tick(0, 0, 0);
    idle();
    #2; chk("st_clear", {31'b0, md_busy}, 0);
    chk_perf("pre_rst");

    // Reset mid-multdiv on r12; a later completion is spurious
    idle(); md_issue = 1; md_rd = 12;
    tick(0, 0, 0);
    idle();
    #2; chk("r12_busy", {31'b0, md_busy}, 1);
    reset = 1'b0;
    m_wr_en = 1; m_wr_reg = 3; m_is_load = 1; set_rs(3, 0, 2'b01);
    exp_lu = 0; exp_md = 0; exp_fw = 0;
    #1;
    chk("r12_rst_busy", {31'b0, md_busy}, 0);
    chk("r12_rst_stall", {31'b0, stall}, 0);
    chk_perf("in_rst");
    tick(0, 0, 0);
    reset = 1'b1;
    idle();
    #2; chk("r12_post_busy", {31'b0, md_busy}, 0);
    tick(0, 0, 0);
    idle(); set_rs(12, 0, 2'b01); md_done = 1; md_rd = 12; md_data = 32'hDEAD;
    hold_data[31:0] = 32'hC0C0;
    #2;
    chk("r12_spur_fwd", fwd_data[31:0], 32'hC0C0);
    chk("r12_spur_stall", {31'b0, stall}, 0);
    tick(0, 0, 0);
    idle(); set_rs(12, 0, 2'b01);
    #2;
    chk("r12_no_raw", {31'b0, stall}, 0);
    chk("r12_busy_after", {31'b0, md_busy}, 0);
    tick(0, 0, 0);

    // Issue to r0 is discarded
    idle(); md_issue = 1; md_rd = 0;
    #2; chk("rd0_stall", {31'b0, stall}, 0);
    tick(0, 0, 0);
    idle();
    #2; chk("rd0_busy", {31'b0, md_busy}, 0);
    tick(0, 0, 0);

    // r0 read while MEM writes r0
    idle(); m_wr_en = 1; m_wr_reg = 0; m_data = 32'hFFFF; set_rs(0, 0, 2'b11);
    #2;
    chk("r0_fwd0", fwd_data[31:0], 32'h0);
    chk("r0_stall", {31'b0, stall}, 0);
    tick(0, 0, 0);
    idle();
    #2;
    chk_perf("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fwd_scoreboard.md
FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 SHALL provide these parameters:
- DW, default 32, datapath width.
- NREG, default 32, register count; AW = clog2(NREG).
- NPORT, default 2, EX read ports.
REQ-002 SHALL provide these ports (clock and reset first):
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- ex_rs  in  NPORT*AW  EX source register numbers; port p at [p*AW +: AW]
- ex_rs_vld  in  NPORT  source p is actually read
- hold_data  in  NPORT*DW  register-file values for each port
- m_wr_en  in  1  MEM-stage instruction writes a register
- m_wr_reg  in  AW  MEM destination register
- m_is_load  in  1  MEM instruction is a load (data not yet valid)
- m_data  in  DW  MEM result
- w_wr_en, w_wr_reg, w_data  in  1/AW/DW  writeback write
- md_issue  in  1  multdiv issued from EX this cycle
- md_rd  in  AW  multdiv destination register
- md_done  in  1  multdiv result valid (one-cycle pulse)
- md_data  in  DW  multdiv result
- fwd_data  out  NPORT*DW  operand for each port after forwarding
- stall  out  1  freeze PC/FD/DX; insert bubble into XM
- md_busy  out  1  multdiv in flight

Function
REQ-003 SHALL forward by priority, per port p, combinationally:
- source reg 0 -> zero;
- else MEM match (m_wr_en, not m_is_load) -> m_data;
- else md_done with md_rd match -> md_data;
- else WB match -> w_data;
- else hold_data.
REQ-004 SHALL assert load-use stall when a valid port matches m_wr_reg (nonzero) with m_wr_en and m_is_load.
REQ-005 SHALL hold pend_vld/pend_reg: set on md_issue when not stall; cleared on md_done.
REQ-006 SHALL assert RAW stall when pend_vld, not md_done, and a valid nonzero port equals pend_reg.
REQ-007 SHALL assert WAW stall when pend_vld, not md_done, and m_wr_en or w_wr_en targets pend_reg; this prevents a younger write being overwritten.
REQ-008 SHALL assert structural stall when md_issue arrives while pend_vld and not md_done.
REQ-009 SHALL make md_issue and md_done in the same cycle leave pend_vld=1 with pend_reg=md_rd (new op), without a stall.
REQ-010 SHALL drive stall as the OR of REQ-004/006/007/008; md_issue SHALL be ignored while stall=1.
REQ-011 SHALL not set the scoreboard when md_issue has md_rd=0; that result is discarded.
REQ-012 SHALL treat md_done with pend_vld=0 as spurious: ignored, state unchanged.
REQ-013 SHALL drive md_busy = pend_vld, registered.
REQ-014 SHALL give all stall and forward outputs zero-cycle latency from inputs; only scoreboard state is sequential.

Reset
REQ-015 SHALL, while reset=0, asynchronously clear pend_vld, pend_reg and all counters.
REQ-016 SHALL drive stall=0 and md_busy=0 while in reset.
REQ-017 SHALL drop an in-flight multdiv on reset mid-operation; a later md_done SHALL be ignored per REQ-012.

Configuration
REQ-018 SHALL, with FWD_PERF_EN defined, add 32-bit outputs:
- perf_lu: load-use stall cycles;
- perf_md: RAW/WAW/structural stall cycles;
- perf_fwd: cycles any port selected MEM/MD/WB.
REQ-019 SHALL make these counters saturate at all-ones and clear only on reset.
REQ-020 SHALL, with FWD_PERF_EN undefined, omit the counters, their ports and their logic.

Structure
REQ-021 SHALL place the following in shared package fwd_pkg:
- opcode constants;
- the forward-select enum {FS_ZERO, FS_MEM, FS_MD, FS_WB, FS_RF};
- DW/NREG defaults.
REQ-022 SHALL implement one sub-module, fwd_port_mux, instantiated NPORT times in a generate loop; it holds the per-port select and mux.

Verification
REQ-023 SHALL cover these directed scenarios:
- MEM add writes r5=0x11, WB writes r5=0x22, EX reads r5 on port0 -> fwd_data[0]=0x11, stall=0.
- MEM load to r7, EX reads r7 on port1 -> stall=1 for one cycle; next cycle WB forward of load data, stall=0.
- md_issue r9; 3 cycles later EX reads r9 -> stall=1 until the md_done cycle, then fwd_data=md_data, md_busy falls the next cycle.
- md pending r4, second md_issue -> stall=1; md_done and retry in same cycle -> pend_reg=new md_rd, no stall.
- reset pulled low mid-multdiv (pend r12) -> md_busy=0 immediately; later md_done ignored; read of r12 returns hold_data.
- EX reads r0 while MEM writes r0=0xFFFF -> fwd_data=0, stall=0; with FWD_PERF_EN, perf counters match the stall counts of the preceding scenarios.
